// File: rtl/roll_pkg.sv
// rtl/roll_pkg.sv - shared states, die table and LFSR constants for the dice roll sequencer
package roll_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_LOAD,
        ST_SPIN,
        ST_DONE
    } roll_state_t;

    localparam int NUM_DICE = 7;
    localparam int DIE_D4   = 0;
    localparam int DIE_D6   = 1;
    localparam int DIE_D8   = 2;
    localparam int DIE_D10  = 3;
    localparam int DIE_D12  = 4;
    localparam int DIE_D20  = 5;
    localparam int DIE_D100 = 6;

    // Top faces in BCD, entry i belongs to die index i; 00 stands for 100.
    localparam logic [8*NUM_DICE-1:0] TOP_BCD_TABLE =
        {8'h00, 8'h20, 8'h12, 8'h10, 8'h08, 8'h06, 8'h04};

    localparam logic [15:0] LFSR_SEED = 16'hACE1;
    localparam logic [15:0] LFSR_TAPS = 16'hB400;
    localparam logic [4:0]  SPIN_BASE = 5'd16;
    localparam logic [7:0]  RESET_BCD = 8'h01;

    function automatic logic [6:0] lowest_set(input logic [6:0] r);
        return r & (~r + 7'd1);
    endfunction

    function automatic logic [7:0] die_top_bcd(input logic [6:0] onehot);
        logic [7:0] top;
        top = 8'h00;
        for (int i = 0; i < NUM_DICE; i++) begin
            if (onehot[i]) top = top | TOP_BCD_TABLE[i*8 +: 8];
        end
        return top;
    endfunction

endpackage

// File: rtl/bcd_mod_down.sv
// rtl/bcd_mod_down.sv - two-digit BCD down-count by one with wrap from 01 to a given top value
module bcd_mod_down (
    input  logic [7:0] cur_bcd,
    input  logic [7:0] top_bcd,
    output logic [7:0] next_bcd
);

    always_comb begin
        next_bcd = {cur_bcd[7:4], cur_bcd[3:0] - 4'd1};
        if (cur_bcd == 8'h01) begin
            next_bcd = top_bcd;
        end else if (cur_bcd == 8'h00) begin
            // 00 encodes 100, so its successor is 99
            next_bcd = 8'h99;
        end else if (cur_bcd[3:0] == 4'd0) begin
            next_bcd = {cur_bcd[7:4] - 4'd1, 4'h9};
        end
    end

endmodule

// File: rtl/roll_sequencer.sv
// rtl/roll_sequencer.sv - one-at-a-time dice roll controller; ROLL_RETRIGGER_EN lets a req restart a spinning roll
module roll_sequencer
    import roll_pkg::*;
#(
    parameter int TICK_DIV   = 1024,
    parameter int FAST_STEPS = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [6:0] req,
    output logic [7:0] value_bcd,
    output logic [6:0] grant,
    output logic       busy,
    output logic       step,
    output logic       done
);

    localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int IW = $clog2(FAST_STEPS + 2);
    localparam logic [PW-1:0] PRESC_LAST = PW'(TICK_DIV - 1);
    localparam logic [4:0]    FAST_REM   = 5'(FAST_STEPS);
    localparam logic [IW-1:0] FAST_IVL   = IW'(FAST_STEPS + 1);

    roll_state_t   state;
    logic [PW-1:0] presc;
    logic [15:0]   lfsr;
    logic [4:0]    remaining;
    logic [IW-1:0] ivl;

    logic          tick;
    logic          retrigger;
    logic [6:0]    req_pick;
    logic [7:0]    top_bcd;
    logic [7:0]    next_bcd;
    logic [4:0]    rem_dec;
    logic [IW-1:0] ivl_dec;

    assign tick     = (presc == '0);
    assign req_pick = lowest_set(req);
    assign top_bcd  = die_top_bcd(grant);
    assign rem_dec  = remaining - 5'd1;
    assign ivl_dec  = ivl - IW'(1);

`ifdef ROLL_RETRIGGER_EN
    assign retrigger = (state == ST_SPIN) && (req != 7'd0);
`else
    assign retrigger = 1'b0;
`endif

    bcd_mod_down u_mod_down (
        .cur_bcd  (value_bcd),
        .top_bcd  (top_bcd),
        .next_bcd (next_bcd)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= ST_IDLE;
            presc     <= '0;
            lfsr      <= LFSR_SEED;
            remaining <= '0;
            ivl       <= '0;
            value_bcd <= RESET_BCD;
            grant     <= '0;
            busy      <= 1'b0;
            step      <= 1'b0;
            done      <= 1'b0;
        end else begin
            presc <= (presc == PRESC_LAST) ? '0 : presc + PW'(1);
            lfsr  <= {1'b0, lfsr[15:1]} ^ (lfsr[0] ? LFSR_TAPS : 16'h0000);
            step  <= 1'b0;
            done  <= 1'b0;

            case (state)
                ST_IDLE: begin
                    if (req != 7'd0) begin
                        grant <= req_pick;
                        state <= ST_LOAD;
                    end
                end

                ST_LOAD: begin
                    value_bcd <= top_bcd;
                    remaining <= SPIN_BASE + {1'b0, lfsr[3:0]};
                    ivl       <= IW'(1);
                    busy      <= 1'b1;
                    state     <= ST_SPIN;
                end

                ST_SPIN: begin
                    if (retrigger) begin
                        grant <= req_pick;
                        state <= ST_LOAD;
                    end else if (tick) begin
                        if (ivl_dec == '0) begin
                            value_bcd <= next_bcd;
                            step      <= 1'b1;
                            remaining <= rem_dec;
                            if (rem_dec == 5'd0) begin
                                done  <= 1'b1;
                                busy  <= 1'b0;
                                state <= ST_DONE;
                            end else if (rem_dec > FAST_REM) begin
                                ivl <= IW'(1);
                            end else begin
                                // the last steps wait 1, 2, ... FAST_STEPS ticks
                                ivl <= FAST_IVL - IW'(rem_dec);
                            end
                        end else begin
                            ivl <= ivl_dec;
                        end
                    end
                end

                ST_DONE: begin
                    state <= ST_IDLE;
                end

                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_roll_sequencer.sv
// tb/tb_roll_sequencer.sv - randomized bench with a schedule-based roll model for roll_sequencer
module tb_roll_sequencer;

    localparam int TICK_DIV   = 4;
    localparam int FAST_STEPS = 8;

    logic       clk = 1'b0;
    logic       rst;
    logic [6:0] req;
    logic [7:0] value_bcd;
    logic [6:0] grant;
    logic       busy;
    logic       step;
    logic       done;

    roll_sequencer #(
        .TICK_DIV   (TICK_DIV),
        .FAST_STEPS (FAST_STEPS)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .req       (req),
        .value_bcd (value_bcd),
        .grant     (grant),
        .busy      (busy),
        .step      (step),
        .done      (done)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;

    int faces [7] = '{4, 6, 8, 10, 12, 20, 100};

    // model: the whole roll is precomputed as the list of cycles where each new face appears
    int          cyc;
    logic [15:0] m_lfsr;
    bit          roll_on;
    int          m_load;
    int          m_ns;
    int          m_n;
    logic [6:0]  m_grant;
    int          step_cyc [1:31];
    logic [7:0]  load_hold;
    logic [7:0]  last_value;

    logic [7:0]  e_value;
    logic [6:0]  e_grant;
    bit          e_busy, e_busy_known, e_step, e_done;

    logic [7:0]  obs_vals [0:31];
    int          obs_n;
    int          done_c_obs;
    logic [7:0]  final_v;
    int          launch_load;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic logic [15:0] lfsr_adv(input logic [15:0] x);
        logic [15:0] y;
        y = x >> 1;
        if (x[0]) y = y ^ 16'hB400;
        return y;
    endfunction

    function automatic logic [7:0] to_bcd(input int m);
        if (m == 100) return 8'h00;
        return {4'(m / 10), 4'(m % 10)};
    endfunction

    function automatic bit model_idle(input int c);
        return !roll_on || (c > step_cyc[m_ns]);
    endfunction

    task automatic start_roll(input logic [6:0] r);
        int idx, t, rr, d, cnt;
        idx = -1;
        for (int i = 0; i < 7; i++) if (r[i] && idx < 0) idx = i;
        m_grant   = 7'd1 << idx;
        m_n       = faces[idx];
        m_load    = cyc + 1;
        m_ns      = 16 + int'(lfsr_adv(m_lfsr) & 16'h000F);
        load_hold = last_value;
        roll_on   = 1'b1;
        t = m_load + 1;
        for (int j = 1; j <= m_ns; j++) begin
            rr  = m_ns - j + 1;
            d   = (rr > FAST_STEPS) ? 1 : FAST_STEPS + 1 - rr;
            cnt = 0;
            while (cnt < d) begin
                if (t % TICK_DIV == 0) cnt++;
                if (cnt < d) t++;
            end
            step_cyc[j] = t + 1;
            t = t + 1;
        end
    endtask

    task automatic model_expect(input int c);
        int k;
        e_grant = roll_on ? m_grant : 7'd0;
        e_step  = 1'b0;
        e_done  = 1'b0;
        if (!roll_on) begin
            e_value = 8'h01; e_busy = 1'b0; e_busy_known = 1'b1;
        end else if (c <= m_load) begin
            e_value = load_hold; e_busy = 1'b0; e_busy_known = 1'b0;
        end else begin
            k = 0;
            for (int j = 1; j <= m_ns; j++) begin
                if (step_cyc[j] <= c) k++;
                if (step_cyc[j] == c) e_step = 1'b1;
            end
            e_value      = to_bcd(m_n - (k % m_n));
            e_done       = (c == step_cyc[m_ns]);
            e_busy       = (c < step_cyc[m_ns]);
            e_busy_known = 1'b1;
        end
    endtask

    always @(posedge clk) begin
        if (rst) begin
            cyc        = 0;
            m_lfsr     = 16'hACE1;
            roll_on    = 1'b0;
            m_ns       = 1;
            m_load     = 0;
            last_value = 8'h01;
            m_grant    = 7'd0;
        end else begin
            if (req != 7'd0) begin
                if (model_idle(cyc)) start_roll(req);
`ifdef ROLL_RETRIGGER_EN
                else if (cyc > m_load && cyc < step_cyc[m_ns]) start_roll(req);
`endif
            end
            m_lfsr = lfsr_adv(m_lfsr);
            cyc++;
        end
    end

    always @(negedge clk) begin
        if (!rst) begin
            model_expect(cyc);
            chk("value_bcd", value_bcd, e_value);
            chk("grant", grant, e_grant);
            if (e_busy_known) chk("busy", busy, e_busy);
            chk("step", step, e_step);
            chk("done", done, e_done);
            chk("bcd_digits", (value_bcd[3:0] <= 4'd9) && (value_bcd[7:4] <= 4'd9), 1);
            last_value = e_value;
        end
    end

    task automatic launch(input logic [6:0] r, input int target);
        int guard;
        guard = 0;
        @(posedge clk); #1;
        if (target >= 0) begin
            while (((lfsr_adv(m_lfsr) & 16'h000F) != 16'(target)) && guard < 5000) begin
                @(posedge clk); #1;
                guard++;
            end
            chk("lfsr_align", guard < 5000, 1);
        end
        req = r;
        launch_load = cyc + 1;
        @(posedge clk); #1;
        req = 7'd0;
    endtask

    task automatic watch_roll(input int budget);
        bit got;
        got   = 1'b0;
        obs_n = 0;
        for (int i = 0; i < budget && !got; i++) begin
            @(negedge clk);
            if (step === 1'b1) begin
                if (obs_n < 32) obs_vals[obs_n] = value_bcd;
                obs_n++;
            end
            if (done === 1'b1) begin
                got        = 1'b1;
                done_c_obs = cyc;
                final_v    = value_bcd;
            end
        end
        chk("done_seen", got, 1);
    endtask

    function automatic int spin_ticks();
        int n;
        n = 0;
        for (int c = launch_load + 1; c < done_c_obs; c++) if (c % TICK_DIV == 0) n++;
        return n;
    endfunction

    initial begin
        #900000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1;
        req = 7'd0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_value", value_bcd, 8'h01);
        chk("rst_grant", grant, 7'd0);
        chk("rst_busy", busy, 0);
        chk("rst_step", step, 0);
        chk("rst_done", done, 0);
        @(negedge clk); #2;
        rst = 1'b0;

        // priority: d6 beats d10
        launch(7'b0001010, -1);
        chk("prio_grant", grant, 7'b0000010);
        @(posedge clk); #1;
        chk("prio_value", value_bcd, 8'h06);
        chk("prio_busy", busy, 1);
        watch_roll(1500);

        // d4 with Ns = 16
        launch(7'b0000001, 0);
        watch_roll(1500);
        chk("d4_steps", obs_n, 16);
        chk("d4_ticks", spin_ticks(), 44);
        chk("d4_final", final_v, 8'h04);
        chk("d4_seq0", obs_vals[0], 8'h03);
        chk("d4_seq1", obs_vals[1], 8'h02);
        chk("d4_seq2", obs_vals[2], 8'h01);
        chk("d4_seq3", obs_vals[3], 8'h04);

        // d100 with Ns = 17
        launch(7'b1000000, 1);
        watch_roll(1500);
        chk("d100_steps", obs_n, 17);
        chk("d100_first", obs_vals[0], 8'h99);
        chk("d100_second", obs_vals[1], 8'h98);
        chk("d100_final", final_v, 8'h83);

        // d20 with Ns = 31
        launch(7'b0100000, 15);
        watch_roll(1500);
        chk("d20_steps", obs_n, 31);
        chk("d20_borrow", obs_vals[10], 8'h09);
        chk("d20_wrap", obs_vals[19], 8'h20);
        chk("d20_final", final_v, 8'h09);

        // d8 request while a d20 roll spins
        launch(7'b0100000, -1);
        repeat (20) @(posedge clk);
        #1;
        req = 7'b0000100;
        @(posedge clk); #1;
        req = 7'd0;
`ifdef ROLL_RETRIGGER_EN
        @(posedge clk); #1;
        chk("retrig_value", value_bcd, 8'h08);
        chk("retrig_grant", grant, 7'b0000100);
        watch_roll(1500);
        chk("retrig_done_grant", grant, 7'b0000100);
`else
        chk("noretrig_grant", grant, 7'b0100000);
        watch_roll(1500);
        chk("noretrig_done_grant", grant, 7'b0100000);
`endif

        // asynchronous reset in the middle of a spin
        launch(7'b0010000, -1);
        repeat (30) @(negedge clk);
        #2;
        rst = 1'b1;
        #1;
        chk("arst_value", value_bcd, 8'h01);
        chk("arst_grant", grant, 7'd0);
        chk("arst_busy", busy, 0);
        chk("arst_step", step, 0);
        chk("arst_done", done, 0);
        repeat (2) @(posedge clk);
        @(negedge clk); #2;
        rst = 1'b0;
        launch(7'b0000010, -1);
        watch_roll(1500);
        chk("post_rst_grant", grant, 7'b0000010);

        // random rolls, stray requests during SPIN and DONE
        for (int n = 0; n < 12; n++) begin
            repeat ($urandom_range(0, 10)) @(posedge clk);
            launch(7'($urandom_range(1, 127)), -1);
            if ($urandom_range(0, 2) == 0) begin
                repeat ($urandom_range(5, 60)) @(posedge clk);
                #1;
                req = 7'($urandom_range(1, 127));
                @(posedge clk); #1;
                req = 7'd0;
            end
            watch_roll(1500);
            if ($urandom_range(0, 1) == 1) begin
                #1;
                req = 7'($urandom_range(1, 127));
                @(posedge clk); #1;
                req = 7'd0;
            end
        end

        repeat (4) @(posedge clk);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/roll_sequencer.md
# roll_sequencer

Controller that sequences one dice roll at a time. It grants one of seven debounced die-select strobes and loads that die's face count into a two-digit BCD value. It then spins the value downward in mod-N steps that slow toward the end, and stops on a pseudo-random face. It sits between the debouncers and the output pins: `value_bcd` drives `uo_out` directly, and `busy`, `step` and `done` drive the status pins or LEDs.

## Interface
Parameters:
- `TICK_DIV`, default 1024: prescaler period in clk cycles. One tick is produced per period; with a 32768 Hz clock the default gives 32 Hz.
- `FAST_STEPS`, default 8: the number of final steps that run at the slowing rate.

Ports:
- `clk` in 1: system clock.
- `rst` in 1: reset, asynchronous, active-high.
- `req` in 7: one-cycle debounced strobes. Bit order is d4, d6, d8, d10, d12, d20, d100 (bit 0 = d4).
- `value_bcd` out 8: current face in BCD, {tens, ones}. 8'h00 means 100 for d100.
- `grant` out 7: one-hot code of the die that was last granted; held until the next grant.
- `busy` out 1: high during LOAD and SPIN.
- `step` out 1: one-cycle pulse on every face change during SPIN.
- `done` out 1: one-cycle pulse when a roll finishes.

## Operation
- **Prescaler:** free-running counter from 0 to TICK_DIV-1. `tick` = (prescaler == 0).
- **LFSR:** 16-bit Galois, polynomial x^16+x^14+x^13+x^11+1. Advances every clk. Reset value 16'hACE1.
- **States:** IDLE, LOAD, SPIN, DONE.
- **IDLE:** when `req != 0`, grant the lowest set bit (d4 has highest priority) and go to LOAD. Other set bits are dropped.
- **LOAD:** one cycle.
  - `value_bcd` <= the die's top value: 04, 06, 08, 10, 12, 20 or 00.
  - `remaining` <= 16 + lfsr[3:0], giving a 5-bit range of 16..31.
  - `ivl` <= 1.
  - Next state: SPIN.
- **SPIN:** on each tick, `ivl` decrements. When `ivl` reaches 0:
  - Decrement `value_bcd` mod N:
    - 01 -> top value.
    - x0 -> (x-1)9.
    - 00 -> 99 (d100 only).
    - Otherwise ones-1.
  - Pulse `step`; `remaining` -= 1.
  - If the new `remaining` == 0, go to DONE.
  - Otherwise reload `ivl` = 1 if `remaining` > FAST_STEPS, else FAST_STEPS+1-`remaining`.
- **DONE:** one cycle. Pulse `done`, then return to IDLE. `value_bcd` holds the result.
- A `req` arriving in LOAD or DONE is dropped. A `req` in SPIN is handled as described under Configuration.
- The BCD ones digit never exceeds 9. Invalid BCD never appears on `value_bcd`.

## Timing
- **Reset values:** `value_bcd` = 8'h01, `grant` = 0, `busy` = 0, `step` = 0, `done` = 0. State = IDLE, prescaler = 0.
- Reset asserted mid-roll aborts immediately to the reset values.
- **Latencies:**
  - `req` at edge k -> LOAD during cycle k+1.
  - `value_bcd` shows the top value, and `busy` = 1, from edge k+2.
- `step` is asserted in the same cycle as the `value_bcd` update it marks; this is always a tick cycle.
- Total SPIN length = (Ns - FAST_STEPS) + FAST_STEPS·(FAST_STEPS+1)/2 ticks, where Ns is the loaded `remaining`. With defaults this is Ns+28 ticks. The first interval is measured from the first tick after LOAD.
- **Final value:** N - (Ns mod N), with a result of 0 mapped to the top value.
- `busy` falls in the DONE cycle, the same cycle as the `done` pulse.

## Configuration
- **`ROLL_RETRIGGER_EN` defined:** a `req` seen during SPIN re-arbitrates and goes to LOAD on the next cycle, restarting the roll with the new die. `done` is not pulsed for the aborted roll.
- **`ROLL_RETRIGGER_EN` not defined:** `req` is ignored in every state except IDLE.

## Structure
- **Shared package `roll_pkg`:** state enum; die index constants; top-value BCD table (04, 06, 08, 10, 12, 20, 00); LFSR seed and tap mask; constant 16 for the spin base.
- **Sub-module `bcd_mod_down`:** combinational. Inputs are the current BCD value and the top value; output is the next value with the wrap rules above. Keep it a separate module so it can be reused by other counters.

## Test plan
All scenarios use TICK_DIV=4.
- **Reset:** assert `rst` mid-SPIN -> outputs return to 01/0/0/0/0 asynchronously; the first `req` after reset behaves normally.
- **Priority:** pulse `req` = 7'b0001010 (d6 and d10) in IDLE -> `grant` = 7'b0000010, `value_bcd` = 8'h06 two edges later.
- **d4 full roll:** force `lfsr[3:0]` = 0 at LOAD (Ns = 16) -> 16 `step` pulses, sequence 04→03→02→01→04…, final value 04. `done` comes 44 ticks after LOAD; the last 8 intervals are 1..8 ticks.
- **d100 wrap:** Ns = 17 from top value 00 -> the first steps show 99, 98, …; final value 83. `value_bcd` never holds a non-BCD nibble.
- **d20 BCD borrow:** Ns = 31 -> the value passes 20→19→…→10→09→…→01→20; final value 09.
- **Retrigger:** `req` d8 during SPIN.
  - `ROLL_RETRIGGER_EN` defined: `value_bcd` = 08 two edges later, with no `done` pulse for the aborted roll.
  - Not defined: the request is ignored and the original roll completes.
